rotor_return_stage: RTL and testbench

Return-path (reflector → keyboard) stage for one Enigma rotor slot: accepts an ASCII character after the reflector, applies the inverse of the slot's rotor wiring at the current rotor position, and presents the result one cycle later. It owns the rotor position register and notch carry, and is the backward-direction counterpart of the forward rotor substitution stage. Case is preserved; non-letters map to '?'.

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/rotor_inv_map.sv | 38 +++
 rtl/rotor_return_stage.sv | 83 ++++++++
 tb/tb_rotor_return_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: ASCII anchors, alphabet size, inverse rotor III wiring
// and the modulo-26 adder used by the substitution datapath.
package enigma_pkg;

   localparam logic [7:0] CH_A  = 8'h41;
   localparam logic [7:0] CH_a  = 8'h61;
   localparam logic [7:0] CH_Q  = 8'h3F;
   localparam logic [4:0] ALPHA = 5'd26;

   // "TAGBPCSDQEUFVNZHYIXJWLRKOM" as indices, element 0 first
   localparam logic [0:25][4:0] INV_III = {
      5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16,
      5'd4,  5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,
      5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12
   };

   // Operands must sum below 52 so a single conditional subtract suffices
   function automatic logic [4:0] mod26_add(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, ALPHA}) begin
         sum = sum - {1'b0, ALPHA};
      end
      return sum[4:0];
   endfunction

endpackage

// File: rtl/rotor_inv_map.sv
// Combinational inverse rotor III substitution of one ASCII char at a given position.
// Zero latency, no flow control; case preserved, non-letters become '?'.
module rotor_inv_map
   import enigma_pkg::*;
(
   input  logic [7:0] char_in,
   input  logic [4:0] pos,
   output logic [7:0] char_out
);

   logic       is_letter;
   logic [7:0] base;
   logic [7:0] off;
   logic [4:0] s;
   logic [4:0] m;
   logic [4:0] r;

   always_comb begin
      is_letter = 1'b0;
      base      = CH_A;
      off       = 8'h00;
      if (char_in >= CH_A && char_in <= (CH_A + 8'd25)) begin
         is_letter = 1'b1;
         base      = CH_A;
         off       = char_in - CH_A;
      end else if (char_in >= CH_a && char_in <= (CH_a + 8'd25)) begin
         is_letter = 1'b1;
         base      = CH_a;
         off       = char_in - CH_a;
      end
      s = mod26_add(off[4:0], pos);
      m = INV_III[s];
      // adding (26 - pos) is the wrap-safe form of subtracting pos
      r = mod26_add(m, ALPHA - pos);
      char_out = is_letter ? (base + {3'b000, r}) : CH_Q;
   end

endmodule

// File: rtl/rotor_return_stage.sv
// Return-path rotor stage: inverse substitution into a one-entry output buffer, plus position/notch carry.
// One-cycle latency, full throughput; in_ready = buffer empty or downstream ready, output held while stalled.
module rotor_return_stage
   import enigma_pkg::*;
#(
   parameter logic [4:0] NOTCH    = 5'd21,
   parameter logic [4:0] INIT_POS = 5'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       load,
   input  logic [4:0] pos_in,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_char,
   input  logic       out_ready,
   output logic [4:0] pos_out,
   output logic       carry_out
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

   buf_state_t state_q, state_d;
   logic [7:0] out_char_q, out_char_d;
   logic [4:0] pos_q, pos_d;
   logic       carry_q, carry_d;
   logic [7:0] mapped_char;
   logic       accept;

   // Substitution always sees the pre-update position
   rotor_inv_map u_map (
      .char_in  (in_char),
      .pos      (pos_q),
      .char_out (mapped_char)
   );

   assign in_ready  = (state_q == EMPTY) || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == FULL);
   assign out_char  = out_char_q;
   assign pos_out   = pos_q;
   assign carry_out = carry_q;

   always_comb begin
      state_d    = state_q;
      out_char_d = out_char_q;
      if (accept) begin
         state_d    = FULL;
         out_char_d = mapped_char;
      end else if (state_q == FULL && out_ready) begin
         state_d = EMPTY;
      end
   end

   always_comb begin
      pos_d   = pos_q;
      carry_d = 1'b0;
      if (load && pos_in <= 5'd25) begin
         pos_d = pos_in;
      end else if (step && !load) begin
         pos_d   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
         carry_d = (pos_q == NOTCH);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         out_char_q <= 8'h00;
         pos_q      <= INIT_POS;
         carry_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_char_q <= out_char_d;
         pos_q      <= pos_d;
         carry_q    <= carry_d;
      end
   end

endmodule

// File: tb/tb_rotor_return_stage.sv
// Self-checking bench for rotor_return_stage: directed and random steps against a forward-wiring search model.
module tb_rotor_return_stage;

   localparam logic [4:0] NOTCH_P = 5'd21;
   localparam logic [4:0] INIT_P  = 5'd0;
   localparam string      ROTOR_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";

   logic       clk = 1'b0;
   logic       rst;
   logic       step, load, in_valid, out_ready;
   logic [4:0] pos_in;
   logic [7:0] in_char;
   logic       in_ready, out_valid, carry_out;
   logic [7:0] out_char;
   logic [4:0] pos_out;

   int checks = 0;
   int errors = 0;

   int         m_pos;
   bit         m_full;
   logic [7:0] m_char;
   bit         m_carry;
   logic [7:0] stream_q[$];

   always #5 clk = ~clk;

   rotor_return_stage #(.NOTCH(NOTCH_P), .INIT_POS(INIT_P)) dut (
      .clk(clk), .rst(rst), .step(step), .load(load), .pos_in(pos_in),
      .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
      .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
      .pos_out(pos_out), .carry_out(carry_out)
   );

   // Forward rotor: contact c at position p exits at III[(c+p)%26]-p.
   // The return path is whichever contact the forward path would send to idx.
   function automatic logic [7:0] ref_char(input logic [7:0] c, input int p);
      int idx, base;
      if (c >= 8'h41 && c <= 8'h5A) begin idx = int'(c) - 'h41; base = 'h41; end
      else if (c >= 8'h61 && c <= 8'h7A) begin idx = int'(c) - 'h61; base = 'h61; end
      else return 8'h3F;
      for (int r = 0; r < 26; r++) begin
         int w;
         w = int'(ROTOR_III[(r + p) % 26]) - 'h41;
         if ((w - p + 26) % 26 == idx) return 8'(base + r);
      end
      return 8'hxx;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs applied after negedge, outputs checked 1ns after posedge
   task automatic tick(input logic st, input logic ld, input logic [4:0] pin,
                       input logic iv, input logic [7:0] ic, input logic ordy);
      bit         exp_rdy, acc;
      logic [7:0] head;
      step = st; load = ld; pos_in = pin; in_valid = iv; in_char = ic; out_ready = ordy;
      exp_rdy = !m_full || ordy;
      acc = iv && exp_rdy;
      #1;
      check("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
      if (out_valid && ordy) begin
         if (stream_q.size() == 0) begin
            check("stream_underflow", 8'd1, 8'd0);
         end else begin
            head = stream_q.pop_front();
            check("stream_order", out_char, head);
         end
      end
      if (acc) begin
         m_char = ref_char(ic, m_pos);
         m_full = 1;
         stream_q.push_back(m_char);
      end else if (m_full && ordy) begin
         m_full = 0;
      end
      m_carry = 0;
      if (ld && pin <= 5'd25) m_pos = int'(pin);
      else if (st && !ld) begin
         m_carry = (m_pos == int'(NOTCH_P));
         m_pos = (m_pos + 1) % 26;
      end
      @(posedge clk);
      #1;
      check("out_valid", {7'd0, out_valid}, {7'd0, m_full});
      if (m_full) check("out_char", out_char, m_char);
      check("pos_out", {3'd0, pos_out}, 8'(m_pos));
      check("carry_out", {7'd0, carry_out}, {7'd0, m_carry});
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_out_valid", {7'd0, out_valid}, 8'd0);
      check("rst_pos", {3'd0, pos_out}, {3'd0, INIT_P});
      m_pos = int'(INIT_P); m_full = 0; m_char = 8'h00; m_carry = 0;
      stream_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      step = 0; load = 0; pos_in = 0; in_valid = 0; in_char = 0; out_ready = 1;
      rst = 1'b1;
      @(negedge clk);
      do_reset();
      check("rst_out_char", out_char, 8'h00);
      check("rst_carry", {7'd0, carry_out}, 8'd0);
      check("rst_in_ready", {7'd0, in_ready}, 8'd1);

      // Known-answer substitutions at position 0
      tick(0, 0, 0, 1, 8'h42, 1); check("B_at_0", out_char, 8'h41);
      tick(0, 0, 0, 1, 8'h62, 1); check("b_at_0", out_char, 8'h61);
      tick(0, 0, 0, 1, 8'h41, 1); check("A_at_0", out_char, 8'h54);
      tick(0, 1, 5'd1, 0, 8'h00, 1);
      tick(0, 0, 0, 1, 8'h41, 1); check("A_at_1", out_char, 8'h5A);
      tick(0, 1, 5'd0, 0, 8'h00, 1);
      tick(1, 0, 0, 1, 8'h42, 1); check("step_old_pos", out_char, 8'h41);
      check("step_pos", {3'd0, pos_out}, 8'd1);

      // Non-letters, including the neighbours of both letter ranges
      foreach (ROTOR_III[i]) begin end
      tick(0, 0, 0, 1, 8'h35, 1); check("nl_35", out_char, 8'h3F);
      tick(0, 0, 0, 1, 8'h20, 1); check("nl_20", out_char, 8'h3F);
      tick(0, 0, 0, 1, 8'h7B, 1); check("nl_7B", out_char, 8'h3F);
      tick(0, 0, 0, 1, 8'h40, 1);
      tick(0, 0, 0, 1, 8'h5B, 1);
      tick(0, 0, 0, 1, 8'h60, 1);
      tick(0, 0, 0, 0, 8'h00, 1);

      // Notch turnover, wrap without carry, out-of-range load ignored
      tick(0, 1, 5'd21, 0, 8'h00, 1);
      tick(1, 0, 0, 0, 8'h00, 1);
      check("notch_pos", {3'd0, pos_out}, 8'd22);
      check("notch_carry", {7'd0, carry_out}, 8'd1);
      tick(0, 0, 0, 0, 8'h00, 1);
      check("carry_drop", {7'd0, carry_out}, 8'd0);
      tick(0, 1, 5'd25, 0, 8'h00, 1);
      tick(1, 0, 0, 0, 8'h00, 1);
      check("wrap_pos", {3'd0, pos_out}, 8'd0);
      check("wrap_carry", {7'd0, carry_out}, 8'd0);
      tick(0, 1, 5'd30, 0, 8'h00, 1);
      check("bad_load", {3'd0, pos_out}, 8'd0);
      tick(1, 1, 5'd3, 0, 8'h00, 1);
      check("load_over_step", {3'd0, pos_out}, 8'd3);

      // Backpressure: hold for three cycles, then a 26-char stream with random stalls
      tick(0, 0, 0, 1, 8'h48, 1);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 8'h49, 0);
      for (int i = 0; i < 26; i++) begin
         tick(1'($urandom_range(0, 1)), 0, 0, 1, 8'(8'h41 + i), 1'($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 8'h00, 1);
      check("stream_drained", 8'(stream_q.size()), 8'd0);

      // Random traffic across all controls
      for (int i = 0; i < 300; i++) begin
         logic [7:0] c;
         case ($urandom_range(0, 3))
            0: c = 8'(8'h41 + $urandom_range(0, 25));
            1: c = 8'(8'h61 + $urandom_range(0, 25));
            default: c = 8'($urandom);
         endcase
         tick(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 3) != 0));
      end

      // Asynchronous reset while the buffer holds a character
      tick(0, 1, 5'd7, 0, 8'h00, 1);
      tick(0, 0, 0, 1, 8'h51, 0);
      check("pre_rst_full", {7'd0, out_valid}, 8'd1);
      #2;
      do_reset();
      tick(0, 0, 0, 1, 8'h42, 1); check("B_after_rst", out_char, 8'h41);
      tick(0, 0, 0, 0, 8'h00, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
